// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit with HI/LO registers and a countdown busy window.
// Ports:
//   clk        in  1   clock, rising edge
//   reset      in  1   asynchronous active-low reset
//   req        in  1   CP0 flush, blocks acceptance this cycle
//   E_start    in  1   E-stage instruction is a valid MDU op
//   E_mdop     in  4   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 mfhi,8 mflo
//   E_rs/E_rt  in  32  forwarded operands
//   E_busy     out 1   multi-cycle operation in progress
//   E_mdu_out  out 32  mfhi/mflo read data
// Build option: define E_MDU_DIV_EN to include div/divu; otherwise ops 3/4 act as none.
module e_mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        E_start,
    input  logic [3:0]  E_mdop,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    output logic        E_busy,
    output logic [31:0] E_mdu_out
);
    typedef enum logic [3:0] {
        OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO
    } op_e;

    logic [31:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
    logic [3:0]  cnt_q, cnt_d;
    op_e         op_q, op_d, op_in;
    logic        op_ok, accept;
    logic [63:0] prod_s, prod_u;
    logic [31:0] div_q, div_r;
    logic        div_wr;

    assign op_in  = op_e'(E_mdop);
    assign E_busy = cnt_q != 4'd0;
`ifdef E_MDU_DIV_EN
    assign op_ok  = E_mdop >= 4'd1 && E_mdop <= 4'd6;
`else
    assign op_ok  = op_in == OP_MULT || op_in == OP_MULTU || op_in == OP_MTHI || op_in == OP_MTLO;
`endif
    assign accept = E_start && !E_busy && !req && op_ok;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

`ifdef E_MDU_DIV_EN
    logic        sgn;
    logic [31:0] ua, ub, uq, ur;
    // Signed divide via magnitudes: quotient truncates toward zero, remainder takes
    // the dividend's sign. 0x80000000/-1 falls out as 0x80000000 rem 0 naturally.
    assign sgn    = op_q == OP_DIV;
    assign ua     = sgn && a_q[31] ? -a_q : a_q;
    assign ub     = sgn && b_q[31] ? -b_q : b_q;
    assign uq     = ua / (ub == 32'd0 ? 32'd1 : ub);
    assign ur     = ua % (ub == 32'd0 ? 32'd1 : ub);
    assign div_q  = sgn && (a_q[31] ^ b_q[31]) ? -uq : uq;
    assign div_r  = sgn && a_q[31] ? -ur : ur;
    assign div_wr = b_q != 32'd0;
`else
    assign div_q  = 32'd0;
    assign div_r  = 32'd0;
    assign div_wr = 1'b0;
`endif

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        op_d  = op_q;
        if (E_busy) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                if (op_q == OP_MULT) {hi_d, lo_d} = prod_s;
                else if (op_q == OP_MULTU) {hi_d, lo_d} = prod_u;
                else if ((op_q == OP_DIV || op_q == OP_DIVU) && div_wr) begin
                    hi_d = div_r;
                    lo_d = div_q;
                end
            end
        end else if (accept) begin
            if (op_in == OP_MTHI) hi_d = E_rs;
            else if (op_in == OP_MTLO) lo_d = E_rs;
            else begin
                a_d   = E_rs;
                b_d   = E_rt;
                op_d  = op_in;
                cnt_d = (op_in == OP_MULT || op_in == OP_MULTU) ? 4'd5 : 4'd10;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            op_q  <= OP_NONE;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            op_q  <= op_d;
        end
    end

    assign E_mdu_out = op_in == OP_MFHI ? hi_q : op_in == OP_MFLO ? lo_q : 32'd0;
endmodule
